// File: rtl/r4_wb_sequencer.sv
// r4_wb_sequencer: Wishbone front/back end for one radix-4 butterfly stage.
// The management core loads the XR/XI operand sets over the bus and writes
// START; the sequencer steps the butterfly output select through all four
// outputs, holds each one for SETTLE_CYCLES extra cycles, and collects every
// Xro/Xio result into the RESULT readback register.
// Optional build macro R4_SEQ_IRQ_EN adds an irq output, a CTRL IRQ_EN bit
// and its STATUS readback.
module r4_wb_sequencer #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_wb_stall,
    output logic [15:0] xr,
    output logic [15:0] xi,
    output logic [2:0]  c,
    input  logic [3:0]  bf_xro,
    input  logic [3:0]  bf_xio,
`ifdef R4_SEQ_IRQ_EN
    output logic        irq,
`endif
    output logic        busy
);

    localparam logic [7:0] OFF_XR     = 8'h00;
    localparam logic [7:0] OFF_XI     = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
    localparam logic [7:0] OFF_RESULT = 8'h10;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        capture;
    logic        launch;
    logic        finish;

    logic        ack_q;
    logic [31:0] rdata_q;
    logic [15:0] xr_q;
    logic [15:0] xi_q;
    logic        done_q;
    logic        start_pend_q;
    logic        irq_en_q;
    logic        irq_q;
    logic [3:0]  res_xro_q [4];
    logic [3:0]  res_xio_q [4];

    logic        hit;
    logic        req;
    logic        wr;
    logic        rd;
    logic [7:0]  offset;
    logic        ctrl_wr;
    logic        start_req;
    logic        clr_done;
    logic [31:0] rd_mux;
    logic        irq_en_bit;
    logic        unused_data_bits;

    // Bus decode: a new request is only taken when no ack is outstanding,
    // which yields at most one transfer every two cycles.
    always_comb begin
        offset    = i_wb_addr[7:0];
        hit       = (i_wb_addr[31:8] == BASE_ADDR[31:8]);
        req       = i_wb_cyc & i_wb_stb & hit & ~ack_q;
        wr        = req & i_wb_we;
        rd        = req & ~i_wb_we;
        ctrl_wr   = wr & (offset == OFF_CTRL);
        start_req = ctrl_wr & i_wb_data[0] & (state_q != RUN);
        clr_done  = ctrl_wr & i_wb_data[1];
    end

    assign unused_data_bits = &{1'b0, i_wb_data[31:16]};

`ifdef R4_SEQ_IRQ_EN
    assign irq_en_bit = irq_en_q;
    assign irq        = irq_q;
`else
    assign irq_en_bit = 1'b0;
`endif

    // Readback multiplexer; unmapped offsets read as zero.
    always_comb begin
        rd_mux = 32'h0;
        case (offset)
            OFF_XR:     rd_mux = {16'h0, xr_q};
            OFF_XI:     rd_mux = {16'h0, xi_q};
            OFF_CTRL:   rd_mux = 32'h0;
            OFF_STATUS: rd_mux = {26'h0, k_q, 1'b0, irq_en_bit, done_q, busy};
            OFF_RESULT: rd_mux = {res_xio_q[3], res_xio_q[2], res_xio_q[1], res_xio_q[0],
                                  res_xro_q[3], res_xro_q[2], res_xro_q[1], res_xro_q[0]};
            default:    rd_mux = 32'h0;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: walk k through 0..3, holding each output select
    // for SETTLE_CYCLES+1 cycles and capturing on the last one.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        launch  = 1'b0;
        finish  = 1'b0;
        c       = 3'b000;
        case (state_q)
            IDLE: begin
                if (start_pend_q) begin
                    state_d = RUN;
                    k_d     = 2'd0;
                    cnt_d   = 4'd0;
                    launch  = 1'b1;
                end
            end
            RUN: begin
                case (k_q)
                    2'd0:    c = 3'b000;
                    2'd1:    c = 3'b001;
                    2'd2:    c = 3'b010;
                    default: c = 3'b100;
                endcase
                if (cnt_q == SETTLE_LAST) begin
                    capture = 1'b1;
                    cnt_d   = 4'd0;
                    if (k_q == 2'd3) begin
                        state_d = DONE_ST;
                        k_d     = 2'd0;
                        finish  = 1'b1;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE_ST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                k_d     = 2'd0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign busy = (state_q == RUN);

    // Bus-side registers: ack/read data, operands, control and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q        <= 1'b0;
            rdata_q      <= 32'h0;
            xr_q         <= 16'h0;
            xi_q         <= 16'h0;
            done_q       <= 1'b0;
            start_pend_q <= 1'b0;
            irq_en_q     <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            ack_q   <= req;
            rdata_q <= rd ? rd_mux : 32'h0;
            if (wr && (offset == OFF_XR) && !busy) begin
                xr_q <= i_wb_data[15:0];
            end
            if (wr && (offset == OFF_XI) && !busy) begin
                xi_q <= i_wb_data[15:0];
            end
`ifdef R4_SEQ_IRQ_EN
            if (ctrl_wr) begin
                irq_en_q <= i_wb_data[2];
            end
`endif
            if (start_req) begin
                start_pend_q <= 1'b1;
            end else if (launch) begin
                start_pend_q <= 1'b0;
            end
            // A launching sequence always clears DONE, so START beats CLR_DONE.
            if (launch) begin
                done_q <= 1'b0;
            end else if (finish) begin
                done_q <= 1'b1;
            end else if (clr_done) begin
                done_q <= 1'b0;
            end
            irq_q <= (state_q == DONE_ST) & irq_en_q;
        end
    end

    // One result slot per output index, loaded when the sequencer captures k.
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (reset || launch) begin
                res_xro_q[gi] <= 4'h0;
                res_xio_q[gi] <= 4'h0;
            end else if (capture && (k_q == 2'(gi))) begin
                res_xro_q[gi] <= bf_xro;
                res_xio_q[gi] <= bf_xio;
            end
        end
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_data  = rdata_q;
    assign o_wb_stall = 1'b0;
    assign xr         = xr_q;
    assign xi         = xi_q;

endmodule

// File: tb/tb_r4_wb_sequencer.sv
// tb_r4_wb_sequencer: directed bench for r4_wb_sequencer with a behavioural
// butterfly model and a read-data scoreboard queue.
module tb_r4_wb_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [31:0] i_wb_addr = 32'h0;
    logic [31:0] i_wb_data = 32'h0;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;
    logic        o_wb_stall;
    logic [15:0] xr;
    logic [15:0] xi;
    logic [2:0]  c;
    logic [3:0]  bf_xro;
    logic [3:0]  bf_xio;
    logic        busy;
`ifdef R4_SEQ_IRQ_EN
    logic        irq;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];

    int          cyc_idx = 0;
    int          busy_cycles = 0;
    int          last_busy_idx = 0;
    int          irq_count = 0;
    int          irq_idx = 0;
    logic [2:0]  c_log [$];

    always #5 clk = ~clk;

    r4_wb_sequencer #(
        .BASE_ADDR    (BASE),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_wb_cyc  (i_wb_cyc),
        .i_wb_stb  (i_wb_stb),
        .i_wb_we   (i_wb_we),
        .i_wb_addr (i_wb_addr),
        .i_wb_data (i_wb_data),
        .o_wb_ack  (o_wb_ack),
        .o_wb_data (o_wb_data),
        .o_wb_stall(o_wb_stall),
        .xr        (xr),
        .xi        (xi),
        .c         (c),
        .bf_xro    (bf_xro),
        .bf_xio    (bf_xio),
`ifdef R4_SEQ_IRQ_EN
        .irq       (irq),
`endif
        .busy      (busy)
    );

    // Butterfly stand-in: output index k returns nibble k of xr/xi.
    always_comb begin
        bf_xro = 4'h0;
        bf_xio = 4'h0;
        case (c)
            3'b000: begin bf_xro = xr[3:0];   bf_xio = xi[3:0];   end
            3'b001: begin bf_xro = xr[7:4];   bf_xio = xi[7:4];   end
            3'b010: begin bf_xro = xr[11:8];  bf_xio = xi[11:8];  end
            3'b100: begin bf_xro = xr[15:12]; bf_xio = xi[15:12]; end
            default: begin bf_xro = 4'h0; bf_xio = 4'h0; end
        endcase
    end

    // Cycle monitor: busy length, select sequence and irq timing.
    always @(negedge clk) begin
        cyc_idx = cyc_idx + 1;
        if (busy) begin
            busy_cycles = busy_cycles + 1;
            c_log.push_back(c);
            last_busy_idx = cyc_idx;
        end
`ifdef R4_SEQ_IRQ_EN
        if (irq) begin
            irq_count = irq_count + 1;
            irq_idx = cyc_idx;
        end
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transfer; optionally keeps the request asserted through the
    // cycle after ack to show that no second ack follows.
    task automatic wb_access(input logic we_v, input logic [31:0] a, input logic [31:0] d,
                             input logic expect_ack, input logic hold, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd = 32'h0;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we = we_v;
        i_wb_addr = a;
        i_wb_data = d;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk);
            #1;
            if (o_wb_ack) begin
                got = 1'b1;
                rd = o_wb_data;
            end
        end
        if (!hold || !got) begin
            i_wb_cyc = 1'b0;
            i_wb_stb = 1'b0;
            i_wb_we = 1'b0;
        end
        check("ack_seen", {31'h0, got}, {31'h0, expect_ack});
        if (got) begin
            @(posedge clk);
            #1;
            i_wb_cyc = 1'b0;
            i_wb_stb = 1'b0;
            i_wb_we = 1'b0;
            check("ack_single", {31'h0, o_wb_ack}, 32'h0);
            check("data_idle", o_wb_data, 32'h0);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        wb_access(1'b1, a, d, 1'b1, 1'b0, rd);
    endtask

    task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic [31:0] e;
        exp_q.push_back(exp);
        wb_access(1'b0, a, 32'h0, 1'b1, 1'b0, rd);
        e = exp_q.pop_front();
        check(tag, rd, e);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(posedge clk);
            #1;
            if (!busy) done = 1'b1;
        end
        check("busy_end", {31'h0, done}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_sequence();
        logic [2:0] codes [4];
        codes[0] = 3'b000;
        codes[1] = 3'b001;
        codes[2] = 3'b010;
        codes[3] = 3'b100;
        check("busy_len", busy_cycles, 32'd12);
        for (int i = 0; i < 12 && i < c_log.size(); i++) begin
            check("c_step", {29'h0, c_log[i]}, {29'h0, codes[i / 3]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int n;

        // Reset held for three edges.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_xr", {16'h0, xr}, 32'h0);
        check("rst_xi", {16'h0, xi}, 32'h0);
        check("rst_c", {29'h0, c}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ack", {31'h0, o_wb_ack}, 32'h0);
        check("rst_data", o_wb_data, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        wb_read("rst_status", BASE + 32'h0C, 32'h0);
        wb_read("rst_result", BASE + 32'h10, 32'h0);

        // Operand registers; the XR write keeps its request held past ack.
        wb_access(1'b1, BASE + 32'h00, 32'h0000_4321, 1'b1, 1'b1, rd);
        wb_write(BASE + 32'h04, 32'h0000_8765);
        wb_read("rd_xr", BASE + 32'h00, 32'h4321);
        wb_read("rd_xi", BASE + 32'h04, 32'h8765);
        check("pin_xr", {16'h0, xr}, 32'h4321);
        check("pin_xi", {16'h0, xi}, 32'h8765);
        check("stall", {31'h0, o_wb_stall}, 32'h0);

        // Full sequence.
        busy_cycles = 0;
        c_log.delete();
        wb_write(BASE + 32'h08, 32'h1);
        wait_idle();
        check_sequence();
        check("c_after", {29'h0, c}, 32'h0);
        wb_read("result", BASE + 32'h10, 32'h8765_4321);
        wb_read("status_done", BASE + 32'h0C, 32'h2);

        // Busy protection: operand write and second START mid-run.
        busy_cycles = 0;
        c_log.delete();
        wb_write(BASE + 32'h08, 32'h1);
        wb_write(BASE + 32'h00, 32'h0000_FFFF);
        wb_write(BASE + 32'h08, 32'h1);
        wait_idle();
        check("prot_busy_len", busy_cycles, 32'd12);
        check("prot_xr", {16'h0, xr}, 32'h4321);
        wb_read("prot_rd_xr", BASE + 32'h00, 32'h4321);
        wb_read("prot_result", BASE + 32'h10, 32'h8765_4321);

        // START with CLR_DONE: DONE cleared, run starts at k=0.
        wb_write(BASE + 32'h08, 32'h3);
        wb_read("startclr_status", BASE + 32'h0C, 32'h1);
        wait_idle();
        wb_read("startclr_done", BASE + 32'h0C, 32'h2);
        wb_write(BASE + 32'h08, 32'h2);
        wb_read("clr_done", BASE + 32'h0C, 32'h0);

        // Decode: unmapped offset, write-only CTRL, outside window.
        wb_read("unmapped", BASE + 32'h14, 32'h0);
        wb_read("ctrl_rd", BASE + 32'h08, 32'h0);
        wb_access(1'b1, 32'h3000_0100, 32'h1111, 1'b0, 1'b0, rd);
        wb_access(1'b0, 32'h3000_0100, 32'h0, 1'b0, 1'b0, rd);
        wb_read("oow_xr", BASE + 32'h00, 32'h4321);

        // Reset during the fifth busy cycle.
        wb_write(BASE + 32'h08, 32'h1);
        n = busy ? 1 : 0;
        for (int i = 0; i < 20 && n < 5; i++) begin
            @(posedge clk);
            #1;
            if (busy) n++;
        end
        check("mid_busy_reached", n, 32'd5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_busy", {31'h0, busy}, 32'h0);
        check("mid_c", {29'h0, c}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        wb_read("mid_result", BASE + 32'h10, 32'h0);
        wb_read("mid_status", BASE + 32'h0C, 32'h0);

`ifdef R4_SEQ_IRQ_EN
        wb_write(BASE + 32'h00, 32'h0000_4321);
        wb_write(BASE + 32'h04, 32'h0000_8765);
        wb_write(BASE + 32'h08, 32'h4);
        wb_read("irqen_status", BASE + 32'h0C, 32'h4);
        irq_count = 0;
        wb_write(BASE + 32'h08, 32'h5);
        wait_idle();
        check("irq_count", irq_count, 32'd1);
        check("irq_timing", irq_idx - last_busy_idx, 32'd2);
        wb_read("irq_status", BASE + 32'h0C, 32'h6);
        wb_write(BASE + 32'h08, 32'h2);
        wb_write(BASE + 32'h08, 32'h1);
        wait_idle();
        check("irq_gated", irq_count, 32'd1);
        wb_read("irq_off_status", BASE + 32'h0C, 32'h2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/r4_wb_sequencer.md
Name: r4_wb_sequencer

Overview:
Wishbone slave that loads one radix-4 butterfly operand set from the management core and drives it into the R4_butter stage. It steps the butterfly output-select lines through all four output indices and captures each Xro/Xio result into a readback register. It replaces LA-pin operand driving with a bus-programmable, self-sequencing front/back end for R4_butter.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone base address; decode compares i_wb_addr[31:8] with BASE_ADDR[31:8].
SETTLE_CYCLES, 2, extra cycles each output select is held before capture (range 0..15).

Ports:
clk  input  1  system clock (wb_clk_i)
reset  input  1  synchronous active-high reset
i_wb_cyc  input  1  Wishbone cycle
i_wb_stb  input  1  Wishbone strobe
i_wb_we  input  1  write enable
i_wb_addr  input  32  byte address
i_wb_data  input  32  write data
o_wb_ack  output  1  transfer acknowledge
o_wb_data  output  32  read data
o_wb_stall  output  1  stall, tied 0
xr  output  16  {xr3,xr2,xr1,xr0}, 4 bits each, to R4_butter
xi  output  16  {xi3,xi2,xi1,xi0}, to R4_butter
c  output  3  {c3,c2,c1} output select to R4_butter
bf_xro  input  4  R4_butter Xro
bf_xio  input  4  R4_butter Xio
busy  output  1  sequence in progress

Behaviour:
- One clock, clk; reset is synchronous and active-high. All state clears on the clk edge where reset=1.
- Reset values: o_wb_ack=0, o_wb_data=0, xr=0, xi=0, c=3'b000, busy=0, DONE=0, RESULT=0, k=0.
- Register map (offset = i_wb_addr[7:0]):
  - 0x00 XR: RW [15:0].
  - 0x04 XI: RW [15:0].
  - 0x08 CTRL: W-only. bit0=START, bit1=CLR_DONE. Reads return 0.
  - 0x0C STATUS: RO. bit0=busy, bit1=DONE, [5:4]=k.
  - 0x10 RESULT: RO. [3:0],[7:4],[11:8],[15:12] = Xro for k=0..3; [19:16]..[31:28] = Xio for k=0..3.
  - Unmapped offsets, and addresses outside BASE_ADDR: reads return 0, writes are ignored. In-window unmapped offsets are still acked.
- Bus handshake:
  - o_wb_ack pulses high for exactly 1 cycle, in the cycle after the first clock edge where cyc & stb & decode.
  - No ack is issued for a new request while o_wb_ack=1. Back-to-back access rate is therefore 1 per 2 cycles.
  - o_wb_data is valid with ack and returns to 0 otherwise.
- xr and xi drive the XR and XI registers directly.
- Writes to XR/XI while busy=1 are acked but ignored.
- FSM states IDLE, RUN, DONE_ST:
  - IDLE: a START write (acked at edge N) sets busy=1, k=0, and clears RESULT and DONE at edge N+1.
  - RUN: c is driven from k: k0=3'b000, k1=3'b001, k2=3'b010, k3=3'b100. A settle counter runs 0..SETTLE_CYCLES.
  - On the edge where the counter equals SETTLE_CYCLES, {bf_xio,bf_xro} is written into RESULT slot k. Then k increments and the counter clears.
  - Capture at k=3 moves the FSM to DONE_ST.
  - Total busy duration = 4*(SETTLE_CYCLES+1) cycles.
  - DONE_ST: one cycle. Sets DONE=1, busy=0, c=0, k=0, then returns to IDLE.
- DONE is sticky. It clears on a CLR_DONE write or on a new START.
- START while busy=1 is ignored. START and CLR_DONE in the same write: START wins, DONE ends cleared.
- Reset during RUN aborts the sequence immediately; RESULT is cleared.

Optional Feature:
- Macro: R4_SEQ_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) that pulses high for 1 cycle in the cycle after DONE_ST.
  - Adds CTRL bit2=IRQ_EN, RW, reset 0. The pulse is gated by IRQ_EN.
  - STATUS bit2 reads back IRQ_EN.
- Undefined: no irq port, CTRL bit2 ignored, STATUS bit2 reads 0.

Test Plan:
- Reset: assert reset 3 cycles -> all outputs 0, read STATUS=0x0, read RESULT=0x0.
- Register RW: write XR=0x4321, XI=0x8765 -> readback equal, xr=16'h4321, xi=16'h8765, one ack per access, o_wb_stall=0.
- Full sequence: SETTLE_CYCLES=2, bench butterfly model returns Xro=xr_k, Xio=xi_k for c codes k0..k3. Start -> busy high exactly 12 cycles, c steps 000,001,010,100. RESULT=0x8765_4321, STATUS=0x2.
- Busy protection: start, then write XR=0xFFFF and START again mid-RUN -> both acked, xr unchanged, busy length still 12 cycles.
- Reset mid-run: assert reset at 5th busy cycle -> next edge busy=0, c=0, RESULT=0, DONE=0.
- IRQ (R4_SEQ_IRQ_EN defined): IRQ_EN=1 -> one irq pulse one cycle after DONE is set. IRQ_EN=0 -> no pulse; DONE still set.
